sent_rx_crc_check: RTL
======================

SENT_RX_CRC_CHECK -- requirements
Module: sent_rx_crc_check

Interface
REQ-001 Parameter SEED4, default 4'b0101: CRC4 initial register value.
REQ-002 Parameter SEED6, default 6'b010101: CRC6 initial register value.
REQ-003 Parameter ERR_W, default 8: width of each error counter.
REQ-004 clk_rx  in  1  receive clock; all logic on its rising edge; the block shall use one clock only.
REQ-005 reset_n_rx  in  1  reset; synchronous and active-high, despite the _n in the name.
REQ-006 data_fast_check_crc  in  28  fast-channel nibbles, oldest nibble most significant; CRC nibble in [3:0].
REQ-007 data_channel_check_crc  in  30  serial message; enhanced: [29:6] message, [5:0] CRC6; short: [15:4] message, [3:0] CRC4.
REQ-008 done_pre_data  in  3  frame type, held nonzero for 3 or more cycles: 001 = 6 data nibbles; 010 = 4; 011 = 3; 100 = short serial; 101 = enhanced serial; 110/111 = reserved.
REQ-009 crc_valid_fast  out  1  one-cycle pulse: fast-channel result ready.
REQ-010 crc_ok_fast  out  1  fast CRC match; valid while crc_valid_fast=1.
REQ-011 crc_valid_serial  out  1  one-cycle pulse: serial result ready.
REQ-012 crc_ok_serial  out  1  serial CRC match; valid while crc_valid_serial=1.
REQ-013 crc_calc  out  6  computed CRC, zero-extended for CRC4; held until the next result.
REQ-014 crc_rx  out  6  received CRC, zero-extended; held until the next result.
REQ-015 err_cnt_fast / err_cnt_serial  out  ERR_W each  saturating mismatch counters.
REQ-016 busy  out  1  high in LOAD or CALC.
REQ-017 overrun  out  1  sticky; set when a request is dropped.

Function
REQ-018 A request shall be the cycle in which done_pre_data is nonzero and its registered previous value is 000; a held value shall not retrigger.
REQ-019 Reserved codes 110/111 shall be ignored: no state change, no overrun.
REQ-020 FSM states: IDLE, LOAD, CALC, DONE.
REQ-021 IDLE -> LOAD on a request. LOAD -> CALC after one cycle. CALC -> DONE after N cycles. DONE -> IDLE after one cycle.
REQ-022 Request cycle: latch the type, the message left-aligned in a 24-bit shift register, and the received CRC.
REQ-023 LOAD: initialise the CRC register to SEED4, or to SEED6 for type 101.
REQ-024 CRC4 polynomial x^4+x^3+x^2+1. Per bit b, MSB first: fb=r[3]; r={r[2:0],b} XOR (fb ? 4'b1101 : 0).
REQ-025 CRC6 polynomial x^6+x^4+x^3+1. Per bit b, MSB first: fb=r[5]; r={r[4:0],b} XOR (fb ? 6'b011001 : 0).
REQ-026 Each message is augmented with zero bits equal to the CRC width. One bit is processed per CALC cycle.
REQ-027 N = 28 for 001, 20 for 010, 16 for 011, 16 for 100, 30 for 101.
REQ-028 DONE: drive crc_calc and crc_rx, and compare them.
- Fast types (001/010/011): pulse crc_valid_fast and set crc_ok_fast.
- Serial types (100/101): pulse crc_valid_serial and set crc_ok_serial.
REQ-029 Latency: the valid pulse shall occur exactly N+2 cycles after the request cycle.
REQ-030 On a mismatch in DONE, increment the matching error counter. Each counter shall saturate at 2^ERR_W-1 and never wrap.
REQ-031 A request while busy=1 or in DONE shall be dropped and shall set overrun. The calculation in progress shall be unaffected.
REQ-032 A request in the same cycle as DONE shall also be dropped. A request in the cycle after DONE (IDLE) shall be accepted.
REQ-033 crc_ok_* shall hold their last value between pulses.

Reset
REQ-034 While reset_n_rx=1: state=IDLE; all outputs 0; shift and CRC registers 0; previous-request register 000.
REQ-035 A reset asserted mid-CALC shall abort the calculation with no valid pulse and no counter update.
REQ-036 After reset deasserts, a done_pre_data value already nonzero shall not trigger a request until it returns to 000.

Verification
REQ-037 Type 001, data 28'h0000005 -> crc_valid_fast at request+30, crc_ok_fast=1, crc_calc=6'h05.
REQ-038 Type 011, data 28'h0000009 -> pulse at request+18, crc_ok_fast=1. Repeat with [3:0]=4'h8 -> crc_ok_fast=0, err_cnt_fast increments by 1.
REQ-039 Type 101, data 30'h00000026 -> crc_valid_serial at request+32, crc_ok_serial=1, crc_calc=6'h26.
REQ-040 Type 100, data 30'h00000009 -> crc_ok_serial=1. Type 010 with [3:0]=4'hC -> crc_ok_fast=1.
REQ-041 Second request 10 cycles into a type-101 calculation -> overrun=1; first result still correct; no second pulse.
REQ-042 300 mismatching type-001 frames -> err_cnt_fast=255. Reset mid-CALC -> all outputs 0 and no pulse.

Source files
------------

// File: rtl/sent_rx_crc_check.sv
// sent_rx_crc_check: bit-serial CRC4/CRC6 checker for SENT fast and serial frames.
// One request at a time; extra requests are dropped and flagged as overrun.
module sent_rx_crc_check #(
    parameter logic [3:0] SEED4 = 4'b0101,
    parameter logic [5:0] SEED6 = 6'b010101,
    parameter int         ERR_W = 8
) (
    input  logic             clk_rx,
    input  logic             reset_n_rx,
    input  logic [27:0]      data_fast_check_crc,
    input  logic [29:0]      data_channel_check_crc,
    input  logic [2:0]       done_pre_data,
    output logic             crc_valid_fast,
    output logic             crc_ok_fast,
    output logic             crc_valid_serial,
    output logic             crc_ok_serial,
    output logic [5:0]       crc_calc,
    output logic [5:0]       crc_rx,
    output logic [ERR_W-1:0] err_cnt_fast,
    output logic [ERR_W-1:0] err_cnt_serial,
    output logic             busy,
    output logic             overrun
);
    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;
    state_t state, state_nxt;
    logic [2:0] prev, typ;
    logic armed, req, accept, last, serial, enh, match;
    logic [23:0] sr, msg;
    logic [5:0] crc, crc_nxt, rx, rx_in, c6;
    logic [3:0] c4;
    logic [4:0] cnt, n_in;
    // armed stays low until done_pre_data is seen at 000, so a value held through reset cannot trigger
    assign req    = armed && prev == 3'd0 && done_pre_data != 3'd0 && done_pre_data < 3'd6;
    assign accept = req && state == IDLE;
    assign last   = state == CALC && cnt == 5'd0;
    assign serial = typ[2];
    assign enh    = typ == 3'd5;
    assign busy   = state == LOAD || state == CALC;
    always_comb begin
        msg = done_pre_data == 3'd1 ? data_fast_check_crc[27:4] :
              done_pre_data == 3'd2 ? {data_fast_check_crc[19:4], 8'd0} :
              done_pre_data == 3'd3 ? {data_fast_check_crc[15:4], 12'd0} :
              done_pre_data == 3'd4 ? {data_channel_check_crc[15:4], 12'd0} :
                                      data_channel_check_crc[29:6];
        rx_in = done_pre_data == 3'd5 ? data_channel_check_crc[5:0] :
                done_pre_data == 3'd4 ? {2'b00, data_channel_check_crc[3:0]} :
                                        {2'b00, data_fast_check_crc[3:0]};
        n_in = done_pre_data == 3'd1 ? 5'd28 : done_pre_data == 3'd2 ? 5'd20 :
               done_pre_data == 3'd5 ? 5'd30 : 5'd16;
        c4 = {crc[2:0], sr[23]} ^ (crc[3] ? 4'b1101 : 4'b0000);
        c6 = {crc[4:0], sr[23]} ^ (crc[5] ? 6'b011001 : 6'b000000);
        crc_nxt = enh ? c6 : {2'b00, c4};
        match = crc_nxt == rx;
        state_nxt = state == IDLE ? (accept ? LOAD : IDLE) :
                    state == LOAD ? CALC :
                    state == CALC ? (cnt == 5'd0 ? DONE : CALC) : IDLE;
    end
    always_ff @(posedge clk_rx) begin
        if (reset_n_rx) begin
            state <= IDLE;
            prev <= 3'd0;
            armed <= 1'b0;
            typ <= 3'd0;
            sr <= 24'd0;
            crc <= 6'd0;
            rx <= 6'd0;
            cnt <= 5'd0;
            crc_valid_fast <= 1'b0;
            crc_ok_fast <= 1'b0;
            crc_valid_serial <= 1'b0;
            crc_ok_serial <= 1'b0;
            crc_calc <= 6'd0;
            crc_rx <= 6'd0;
            err_cnt_fast <= '0;
            err_cnt_serial <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            prev <= done_pre_data;
            armed <= armed | (done_pre_data == 3'd0);
            crc_valid_fast <= last && !serial;
            crc_valid_serial <= last && serial;
            if (req && state != IDLE) overrun <= 1'b1;
            if (accept) begin
                typ <= done_pre_data;
                sr <= msg;
                rx <= rx_in;
                cnt <= n_in - 5'd1;
            end
            if (state == LOAD) crc <= enh ? SEED6 : {2'b00, SEED4};
            if (state == CALC) begin
                crc <= crc_nxt;
                sr <= {sr[22:0], 1'b0};
                cnt <= cnt - 5'd1;
            end
            if (last) begin
                crc_calc <= crc_nxt;
                crc_rx <= rx;
                if (serial) crc_ok_serial <= match;
                else crc_ok_fast <= match;
                if (!match && !serial && err_cnt_fast != '1) err_cnt_fast <= err_cnt_fast + ERR_W'(1);
                if (!match && serial && err_cnt_serial != '1) err_cnt_serial <= err_cnt_serial + ERR_W'(1);
            end
        end
    end
endmodule
